scan_seq: RTL and testbench
===========================

# scan_seq

Parametrised scan-test sequencer for the CDC benchmark harness. It generalises the fixed single send/recv scan chain into `CHAINS` parallel chains of `LEN` flops each. It streams patterns in, issues either a single capture or a two-step send-launch / recv-capture, and unloads responses into a 16-bit MISR signature. Sits between the pattern source and the `SDFFNSR` chain instances; drives their `SE`, `SI` and per-domain clock enables.

## Interface
- `CHAINS`, default 2: number of parallel scan chains, 1..16.
- `LEN`, default 16: flops per chain, ≥2.
- `MISR_SEED`, default 16'hFFFF: signature value after reset and at each start.
- `CK` input 1: sole clock, rising edge.
- `RST` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request; honoured only in IDLE.
- `mode` input 1: sampled with `start`. 0 means single capture; 1 means launch-then-capture.
- `npat` input 16: number of patterns, sampled with `start`.
- `pat_valid` input 1: a pattern beat is available.
- `pat_data` input CHAINS: one bit per chain for the current beat.
- `pat_ready` output 1: the sequencer accepts a beat this cycle.
- `scan_enable` output 1: drives all chain `SE` inputs.
- `scan_si` output CHAINS: chain serial inputs.
- `shift_en` output 1: chain clock enable for shift cycles.
- `scan_so` input CHAINS: chain serial outputs.
- `cap_send` output 1: capture enable for the send-domain flops.
- `cap_recv` output 1: capture enable for the recv-domain flops.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at completion.
- `signature` output 16: MISR value; stable from DONE until the next accepted `start`.

## Operation
- States are IDLE, SHIFT, CAPL, CAPC, FLUSH and DONE.
- **IDLE.** When `start` is high:
  - latch `mode` and `npat`;
  - set the MISR to `MISR_SEED`;
  - if `npat`=0, go to DONE; otherwise go to SHIFT with beat counter 0 and pattern counter `npat`.
- **SHIFT.**
  - `pat_ready`=1 only in this state. A beat is accepted on the edge where `pat_valid`&`pat_ready`.
  - Each accepted beat produces, next cycle: `scan_si`=`pat_data`, `shift_en`=1, `scan_enable`=1.
  - Without `pat_valid` the state stalls: `shift_en`=0, `scan_enable` stays 1, counters hold.
  - After the LEN-th accepted beat:
    - `mode`=0: go to CAPC.
    - `mode`=1: go to CAPL.
- **CAPL** (one cycle): `scan_enable`=0, `cap_send`=1. Then go to CAPC.
- **CAPC** (one cycle):
  - `scan_enable`=0 and `cap_recv`=1.
  - When `mode`=0, `cap_send`=1 in the same cycle.
  - Decrement the pattern counter. If it is still nonzero go to SHIFT, otherwise go to FLUSH.
- **FLUSH.** LEN shift cycles with `scan_si`=0, `shift_en`=1, `scan_enable`=1 and no beat consumed. Then go to DONE.
- **DONE** (one cycle): `done`=1, then go to IDLE.
- **MISR update.** On every cycle where `shift_en`=1, except during the first pattern's load:
  - sig ← {sig[14:0],0} ^ (sig[15] ? 16'h1021 : 0) ^ zero-extended `scan_so`.
  - The first load's unload data is don't-care and is not absorbed.
- `start` while `busy` is ignored. `pat_data` is never sampled outside SHIFT.

## Timing
- **Reset values:**
  - `signature`=`MISR_SEED`;
  - state IDLE;
  - all other outputs 0.
- `RST` mid-operation aborts at the next edge: no `done` pulse, and the chains are left as-is.
- All outputs are registered.
  - Beat accepted on edge t: `shift_en` and `scan_si` are valid in cycle t+1.
  - `scan_so` is sampled in the same cycle as `shift_en`.
- Back-to-back beats give one shift per cycle. Minimum pattern period is LEN+1 cycles (`mode`=0) or LEN+2 (`mode`=1).
- **Total latency, no stalls.** Measured from the start-accept edge to the `done` cycle: 1 + `npat`·(LEN+1+`mode`) + LEN + 1 cycles.
- **Simultaneous events:**
  - RST beats `start`.
  - A beat on the LEN-th accept moves the state to capture on the same edge.
  - `pat_ready` is 0 during CAPL and CAPC.
- `cap_send` and `cap_recv` are never high while `scan_enable`=1.
- The 16-bit `npat` counter does not wrap; `npat`=0 is legal.

## Test plan
- **Reset/idle.** Assert RST mid-SHIFT. Next cycle: all outputs 0, `signature`=16'hFFFF, `pat_ready`=0. A `start` the cycle after release is honoured.
- **Single capture.** CHAINS=2, LEN=16, `mode`=0, `npat`=1, continuous `pat_valid`.
  - Exactly 16 `shift_en` cycles, then one cycle with `cap_send`=`cap_recv`=1 and `scan_enable`=0, then 16 flush shifts.
  - `done` arrives 35 cycles after start; `signature` matches the reference model of the MISR over the `scan_so` values.
- **Launch/capture.** Same as above with `mode`=1.
  - `cap_send` and `cap_recv` are high in consecutive single cycles and never overlap.
  - `done` arrives 36 cycles after start.
- **Backpressure.** Toggle `pat_valid` 1,0,0,1,…
  - `shift_en` tracks only accepted beats; the MISR holds on stall cycles.
  - Total shifts stay at 16 per pattern.
- **Multi-pattern.** `npat`=3.
  - Unload of pattern k overlaps the load of k+1, and the first load is not absorbed.
  - 48+16 shift cycles in total; 3 capture groups.
  - The signature matches the model; `start` pulses during `busy` are ignored.
- **Degenerate.** `npat`=0: `done` in the cycle after the start edge, `signature`=`MISR_SEED`, no `shift_en` and no captures.

Source files
------------

// File: rtl/scan_seq.sv
// Scan-test sequencer: streams CHAINS-wide pattern beats into LEN-deep chains,
// issues single or launch/capture pulses, and compacts unloaded responses into a MISR.
module scan_seq #(
  parameter int          CHAINS    = 2,
  parameter int          LEN       = 16,
  parameter logic [15:0] MISR_SEED = 16'hFFFF
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic              mode,
  input  logic [15:0]       npat,
  input  logic              pat_valid,
  input  logic [CHAINS-1:0] pat_data,
  output logic              pat_ready,
  output logic              scan_enable,
  output logic [CHAINS-1:0] scan_si,
  output logic              shift_en,
  input  logic [CHAINS-1:0] scan_so,
  output logic              cap_send,
  output logic              cap_recv,
  output logic              busy,
  output logic              done,
  output logic [15:0]       signature
);

  localparam int            CW   = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_CAPL, S_CAPC, S_FLUSH, S_DONE
  } state_t;

  state_t        state_p0, state_nx;
  logic          mode_q;
  logic [15:0]   npat_q;
  logic [15:0]   pat_cnt, pat_cnt_nx;
  logic [CW-1:0] beat_cnt, beat_cnt_nx;
  logic          accept, load_seed, done_nx;
  logic          absorb_p1;

  function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                            input logic [CHAINS-1:0] so);
    logic [15:0] fb;
    fb = sig[15] ? 16'h1021 : 16'h0000;
    return {sig[14:0], 1'b0} ^ fb ^ 16'(so);
  endfunction

  always_comb begin
    state_nx    = state_p0;
    beat_cnt_nx = beat_cnt;
    pat_cnt_nx  = pat_cnt;
    accept      = 1'b0;
    load_seed   = 1'b0;
    done_nx     = 1'b0;
    unique case (state_p0)
      S_IDLE: begin
        if (start) begin
          load_seed   = 1'b1;
          pat_cnt_nx  = npat;
          beat_cnt_nx = '0;
          if (npat == 16'd0) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (pat_valid) begin
          accept = 1'b1;
          if (beat_cnt == LAST) begin
            beat_cnt_nx = '0;
            state_nx    = mode_q ? S_CAPL : S_CAPC;
          end else begin
            beat_cnt_nx = beat_cnt + 1'b1;
          end
        end
      end
      S_CAPL: state_nx = S_CAPC;
      S_CAPC: begin
        pat_cnt_nx = pat_cnt - 16'd1;
        state_nx   = (pat_cnt_nx == 16'd0) ? S_FLUSH : S_SHIFT;
      end
      S_FLUSH: begin
        if (beat_cnt == LAST) begin
          beat_cnt_nx = '0;
          state_nx    = S_DONE;
        end else begin
          beat_cnt_nx = beat_cnt + 1'b1;
        end
      end
      S_DONE: begin
        // a zero-pattern run already pulsed done on its start edge
        done_nx  = (npat_q != 16'd0);
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Stage p0 -> p1: register control outputs one cycle behind the state that
  // produced them; scan_so is absorbed in the cycle its shift_en is visible.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_p0    <= S_IDLE;
      mode_q      <= 1'b0;
      npat_q      <= '0;
      pat_cnt     <= '0;
      beat_cnt    <= '0;
      pat_ready   <= 1'b0;
      scan_enable <= 1'b0;
      scan_si     <= '0;
      shift_en    <= 1'b0;
      cap_send    <= 1'b0;
      cap_recv    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      absorb_p1   <= 1'b0;
      signature   <= MISR_SEED;
    end else begin
      state_p0    <= state_nx;
      pat_cnt     <= pat_cnt_nx;
      beat_cnt    <= beat_cnt_nx;
      if (load_seed) begin
        mode_q <= mode;
        npat_q <= npat;
      end
      pat_ready   <= (state_nx == S_SHIFT);
      busy        <= (state_nx != S_IDLE) || done_nx;
      done        <= done_nx;
      shift_en    <= accept || (state_p0 == S_FLUSH);
      scan_si     <= accept ? pat_data : '0;
      scan_enable <= (state_p0 == S_SHIFT) || (state_p0 == S_FLUSH);
      cap_send    <= (state_p0 == S_CAPL) || ((state_p0 == S_CAPC) && !mode_q);
      cap_recv    <= (state_p0 == S_CAPC);
      // the first pattern's load pushes out stale chain contents
      absorb_p1   <= (accept && (pat_cnt != npat_q)) || (state_p0 == S_FLUSH);
      if (load_seed)
        signature <= MISR_SEED;
      else if (shift_en && absorb_p1)
        signature <= misr_step(signature, scan_so);
    end
  end

endmodule

// File: tb/tb_scan_seq.sv
// Bench for scan_seq: table of whole-run scenarios plus reset corner sequences,
// checked against a transaction-level model of beats, shifts, captures and MISR.
module tb_scan_seq;
  localparam int CHAINS = 2;
  localparam int LEN    = 16;
  localparam logic [15:0] SEED = 16'hFFFF;

  logic              CK = 1'b0;
  logic              RST, start, mode, pat_valid;
  logic [15:0]       npat;
  logic [CHAINS-1:0] pat_data, scan_so;
  logic              pat_ready, scan_enable, shift_en, cap_send, cap_recv, busy, done;
  logic [CHAINS-1:0] scan_si;
  logic [15:0]       signature;

  scan_seq #(.CHAINS(CHAINS), .LEN(LEN), .MISR_SEED(SEED)) dut (
    .CK(CK), .RST(RST), .start(start), .mode(mode), .npat(npat),
    .pat_valid(pat_valid), .pat_data(pat_data), .pat_ready(pat_ready),
    .scan_enable(scan_enable), .scan_si(scan_si), .shift_en(shift_en),
    .scan_so(scan_so), .cap_send(cap_send), .cap_recv(cap_recv),
    .busy(busy), .done(done), .signature(signature)
  );

  always #5 CK = ~CK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // CRC-16/CCITT style step on a 17-bit shift, then fold in the unloaded bits
  function automatic logic [15:0] model_step(input logic [15:0] s, input logic [CHAINS-1:0] so);
    logic [16:0] t;
    t = {s, 1'b0};
    if (t[16]) t = t ^ 17'h11021;
    return t[15:0] ^ {{(16-CHAINS){1'b0}}, so};
  endfunction

  typedef struct {
    logic        m;
    logic [15:0] np;
    int          vstyle;  // 0 continuous, 1 valid 1,0,0 repeating, 2 random
    int          lat;     // expected start-edge to done cycle, -1 when stalls make it variable
    int          sh;
    int          cs;
    int          cr;
    bit          spam;
  } vec_t;

  vec_t vecs[7];

  // Assumes the caller is just after a rising edge; leaves the same way.
  task automatic run_scan(input vec_t v, input string tag);
    logic [CHAINS-1:0] pend[$];
    logic [CHAINS-1:0] exp_si;
    logic [15:0] sig_m;
    int cyc, lat, shifts, beats, cs, cr, both, si_err, trk_err, ovl_err, seq_err, busy_err, hold_err;
    bit prev_send, seen;
    cyc = 0; lat = -1; shifts = 0; beats = 0; cs = 0; cr = 0; both = 0;
    si_err = 0; trk_err = 0; ovl_err = 0; seq_err = 0; busy_err = 0; hold_err = 0;
    prev_send = 0; seen = 0; sig_m = SEED;

    start = 1'b1; mode = v.m; npat = v.np; pat_valid = 1'b0;
    @(posedge CK); #1;
    start = 1'b0;
    cyc = 1;
    while (!seen && cyc < 2000) begin
      case (v.vstyle)
        0:       pat_valid = 1'b1;
        1:       pat_valid = ((cyc - 1) % 3) == 0;
        default: pat_valid = 1'($urandom_range(0, 1));
      endcase
      pat_data = CHAINS'($urandom);
      scan_so  = CHAINS'($urandom);
      if (v.spam && (cyc % 7 == 3) && cyc < 30) begin
        start = 1'b1; mode = ~v.m; npat = 16'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge CK);
      if (signature !== sig_m) trk_err++;
      if (!busy) busy_err++;
      if (shift_en) begin
        shifts++;
        exp_si = (pend.size() > 0) ? pend.pop_front() : '0;
        if (scan_si !== exp_si) si_err++;
        if (shifts > LEN) sig_m = model_step(sig_m, scan_so);
      end
      if (pat_valid && pat_ready) begin
        pend.push_back(pat_data);
        beats++;
      end
      if ((cap_send || cap_recv) && scan_enable) ovl_err++;
      if (cap_send) cs++;
      if (cap_recv) cr++;
      if (cap_send && cap_recv) both++;
      if (cap_recv && (v.m ? !prev_send : !cap_send)) seq_err++;
      prev_send = cap_send;
      if (done) begin
        seen = 1;
        lat  = cyc;
      end else begin
        @(posedge CK); #1;
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    if (v.lat >= 0) check({tag, "_latency"}, lat, v.lat);
    check({tag, "_shift_cycles"}, shifts, v.sh);
    check({tag, "_beats"}, beats, int'(v.np) * LEN);
    check({tag, "_cap_send"}, cs, v.cs);
    check({tag, "_cap_recv"}, cr, v.cr);
    check({tag, "_cap_same_cycle"}, both, v.m ? 0 : int'(v.np));
    check({tag, "_cap_order"}, seq_err, 0);
    check({tag, "_cap_vs_se"}, ovl_err, 0);
    check({tag, "_scan_si"}, si_err, 0);
    check({tag, "_sig_track"}, trk_err, 0);
    check({tag, "_busy"}, busy_err, 0);
    check({tag, "_signature"}, signature, sig_m);
    for (int i = 0; i < 3; i++) begin
      @(posedge CK); #1;
      pat_valid = 1'($urandom_range(0, 1));
      scan_so   = CHAINS'($urandom);
      @(negedge CK);
      if (signature !== sig_m || done || busy || shift_en) hold_err++;
    end
    check({tag, "_idle_hold"}, hold_err, 0);
    @(posedge CK); #1;
  endtask

  initial begin
    vecs[0] = '{m:1'b0, np:16'd1, vstyle:0, lat:35, sh:32, cs:1, cr:1, spam:1'b0};
    vecs[1] = '{m:1'b1, np:16'd1, vstyle:0, lat:36, sh:32, cs:1, cr:1, spam:1'b0};
    vecs[2] = '{m:1'b0, np:16'd3, vstyle:0, lat:69, sh:64, cs:3, cr:3, spam:1'b1};
    vecs[3] = '{m:1'b1, np:16'd2, vstyle:1, lat:-1, sh:48, cs:2, cr:2, spam:1'b0};
    vecs[4] = '{m:1'b0, np:16'd0, vstyle:0, lat:1,  sh:0,  cs:0, cr:0, spam:1'b0};
    vecs[5] = '{m:1'b0, np:16'd2, vstyle:2, lat:-1, sh:48, cs:2, cr:2, spam:1'b1};
    vecs[6] = '{m:1'b1, np:16'd3, vstyle:0, lat:72, sh:64, cs:3, cr:3, spam:1'b0};

    RST = 1'b1; start = 1'b0; mode = 1'b0; npat = '0;
    pat_valid = 1'b0; pat_data = '0; scan_so = '0;
    repeat (3) @(posedge CK);
    #1;
    check("reset_outputs",
          {pat_ready, scan_enable, shift_en, cap_send, cap_recv, busy, done, scan_si}, 0);
    check("reset_signature", signature, SEED);
    RST = 1'b0;
    @(posedge CK); #1;

    for (int k = 0; k < 7; k++) run_scan(vecs[k], $sformatf("v%0d", k));

    // abort in the middle of a load, then restart on the first free edge
    start = 1'b1; mode = 1'b0; npat = 16'd2;
    @(posedge CK); #1;
    start = 1'b0; pat_valid = 1'b1; pat_data = 2'b10; scan_so = 2'b11;
    repeat (6) @(posedge CK);
    #1;
    check("mid_load_shift_en", shift_en, 1);
    check("mid_load_busy", busy, 1);
    RST = 1'b1;
    @(posedge CK); #1;
    RST = 1'b0; pat_valid = 1'b0;
    check("midrst_outputs",
          {pat_ready, scan_enable, shift_en, cap_send, cap_recv, busy, done, scan_si}, 0);
    check("midrst_signature", signature, SEED);
    run_scan(vecs[0], "after_rst");

    // reset held while start is requested from idle
    RST = 1'b1; start = 1'b1; npat = 16'd1; mode = 1'b0;
    @(posedge CK); #1;
    RST = 1'b0; start = 1'b0;
    @(negedge CK);
    check("rst_beats_start", {busy, pat_ready}, 0);
    @(posedge CK); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
